// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares one single-port framebuffer RAM between line
// prefetch into a ping-pong line buffer and host pixel writes.
module fb_scan_arbiter #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 17,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int V_TOTAL   = 525
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              blank,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              busy,
    output logic              underrun
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int NPIX = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_col;
    logic [CW-1:0]     w_col_nxt;
    logic [RW-1:0]     r_row;
    logic [RW-1:0]     w_row_nxt;
    logic              r_cap_vld;
    logic [CW-1:0]     r_cap_col;
    logic              r_cap_bank;
    logic              r_und;
    logic [DATA_W-1:0] r_pix;
    logic [DATA_W-1:0] r_lb [2][IMG_W];

    logic              w_trig;
    logic [RW-1:0]     w_trow;
    logic [ADDR_W-1:0] w_faddr;
    logic              w_wr_ok;
    logic              w_late;
    logic [CW-1:0]     w_hidx;
    logic [DATA_W-1:0] w_lb_rd;

    assign w_trig = (hcount == 10'(H_DISPLAY)) &&
                    (((vcount < 10'(V_DISPLAY - 1)) && vcount[0]) ||
                     (vcount == 10'(V_TOTAL - 1)));
    assign w_trow = (vcount == 10'(V_TOTAL - 1)) ? '0 :
                    RW'((vcount + 10'd1) >> 1);
    assign w_faddr = ADDR_W'(r_row) * ADDR_W'(IMG_W) + ADDR_W'(r_col);
    assign w_wr_ok = wr_addr < ADDR_W'(NPIX);
    // Row still loading when its first display line begins
    assign w_late = (r_state != S_IDLE) && (hcount == 10'd0) &&
                    (vcount[9:1] == 9'(r_row));
    assign w_hidx  = hcount[CW:1];
    assign w_lb_rd = r_lb[vcount[1]][w_hidx];

    assign busy      = (r_state != S_IDLE);
    assign underrun  = r_und;
    assign pix_data  = r_pix;
    assign ram_wdata = wr_data;

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = wr_addr;
        wr_ready    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                wr_ready = !rst && !w_trig;
                if (w_trig) begin
                    w_state_nxt = S_FETCH;
                    w_col_nxt   = '0;
                    w_row_nxt   = w_trow;
                end else if (wr_valid && w_wr_ok && !rst) begin
                    ram_we = 1'b1;
                end
            end
            S_FETCH: begin
                ram_re    = !rst;
                ram_addr  = w_faddr;
                w_col_nxt = r_col + 1'b1;
                if (r_col == CW'(IMG_W - 1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_col  <= '0;
            r_cap_bank <= 1'b0;
            r_und      <= 1'b0;
            r_pix      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_cap_vld  <= ram_re;
            r_cap_col  <= r_col;
            r_cap_bank <= r_row[0];
            if ((w_trig && r_state != S_IDLE) || w_late) begin
                r_und <= 1'b1;
            end
            r_pix <= blank ? '0 : w_lb_rd;
        end
    end

    // Line buffer holds pixel data only; it is intentionally not reset
    always_ff @(posedge clk) begin
        if (r_cap_vld) begin
            r_lb[r_cap_bank][r_cap_col] <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Bench for fb_scan_arbiter: randomized host writes plus scripted scan
// timing, checked through queues against a row-snapshot reference model.
module tb_fb_scan_arbiter;

    localparam int IMG_W = 320;
    localparam int NPIX  = 76800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic        blank = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [16:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic [16:0] ram_addr;
    logic        ram_re;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;
    logic [11:0] pix_data;
    logic        busy;
    logic        underrun;

    fb_scan_arbiter dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .blank(blank), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .ram_addr(ram_addr),
        .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pix_data(pix_data), .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM attached to the DUT
    logic [11:0] mem [NPIX];
    always @(posedge clk) begin
        if (ram_we && ram_addr < NPIX) mem[ram_addr] <= ram_wdata;
        if (ram_re && ram_addr < NPIX) ram_rdata <= mem[ram_addr];
    end

    typedef struct {int cyc; int addr;} rd_t;
    typedef struct {int cyc; bit we; int addr; int data;} wr_t;

    logic [11:0] ref_mem [NPIX];
    logic [11:0] m_lb [2][IMG_W];
    int  m_lb_row [2];
    int  m_lb_rdy [2];
    int  m_start, m_free, m_row;
    bit  m_und;
    int  cyc_n;
    int  vecs, errs;
    bit  host_en;
    bit  pix_tag, pix_tag_d, und_tag;
    int  run;
    rd_t q_rd[$];
    wr_t q_wr[$];
    int  q_busy[$];
    int  q_pix[$];
    bit  q_und[$];

    task automatic check(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc_n);
        end
    endtask

    task automatic new_req();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0)     wr_addr = 17'($urandom_range(NPIX, 131071));
        else if (k < 5) wr_addr = 17'($urandom_range(0, 6 * IMG_W - 1));
        else            wr_addr = 17'($urandom_range(0, NPIX - 1));
        wr_data  = 12'($urandom);
        wr_valid = 1'b1;
    endtask

    // One pixel-clock cycle at scan position (h,v), with model update
    task automatic cyc(input int h, input int v);
        bit  trig, bsy, acc;
        int  b;
        rd_t r;
        wr_t w;
        hcount = 10'(h);
        vcount = 10'(v);
        blank  = (h >= 640) || (v >= 480);
        if (host_en && !wr_valid && $urandom_range(0, 2) == 0) new_req();
        trig = (h == 640) && ((v < 479 && v % 2 == 1) || v == 524);
        bsy  = (cyc_n >= m_start) && (cyc_n < m_free);
        if (trig) begin
            if (bsy) m_und = 1'b1;
            else begin
                m_row   = (v == 524) ? 0 : (v + 1) / 2;
                m_start = cyc_n + 1;
                m_free  = cyc_n + 322;
                b = m_row % 2;
                for (int c = 0; c < IMG_W; c++) begin
                    m_lb[b][c] = ref_mem[m_row * IMG_W + c];
                    r.cyc  = cyc_n + 1 + c;
                    r.addr = m_row * IMG_W + c;
                    q_rd.push_back(r);
                end
                m_lb_row[b] = m_row;
                m_lb_rdy[b] = cyc_n + 323;
                q_busy.push_back(321);
            end
        end
        if (h == 0 && bsy && v / 2 == m_row) m_und = 1'b1;
        acc = wr_valid && !bsy && !trig;
        if (acc) begin
            w.cyc  = cyc_n;
            w.we   = (wr_addr < NPIX);
            w.addr = int'(wr_addr);
            w.data = int'(wr_data);
            q_wr.push_back(w);
            if (wr_addr < NPIX) ref_mem[wr_addr] = wr_data;
        end
        b = (v / 2) % 2;
        pix_tag = 1'b0;
        if (!blank && m_lb_row[b] >= 0 && cyc_n >= m_lb_rdy[b]) begin
            q_pix.push_back(int'(m_lb[b][h / 2]));
            pix_tag = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (acc) wr_valid = 1'b0;
    endtask

    task automatic line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) cyc(h, v);
    endtask

    task automatic probe_und(input int h, input int v);
        q_und.push_back(m_und);
        und_tag = 1'b1;
        cyc(h, v);
        und_tag = 1'b0;
    endtask

    task automatic do_reset(input int n);
        int done;
        host_en  = 1'b0;
        wr_valid = 1'b0;
        pix_tag  = 1'b0;
        und_tag  = 1'b0;
        rst      = 1'b1;
        hcount   = 10'd700;
        blank    = 1'b1;
        if (cyc_n >= m_start && cyc_n < m_free) begin
            done = cyc_n - m_start;
            check("abort_reads_left", q_rd.size(),
                  IMG_W - (done > IMG_W ? IMG_W : done));
            q_rd.delete();
            void'(q_busy.pop_back());
            q_busy.push_back(done);
            m_lb_row[m_row % 2] = -1;
        end
        m_start = 0;
        m_free  = 0;
        m_und   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
        rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT shows activity
    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        if (rst) begin
            check("reset_outputs",
                  {ram_re, ram_we, wr_ready, busy, underrun, |pix_data}, 0);
        end
        if (ram_re || ram_we) check("re_we_overlap", ram_re & ram_we, 0);
        if (ram_re) begin
            if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                r = q_rd.pop_front();
                check("rd_cycle", cyc_n, r.cyc);
                check("rd_addr", int'(ram_addr), r.addr);
            end
        end
        if (wr_valid && wr_ready) begin
            if (q_wr.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                w = q_wr.pop_front();
                check("wr_cycle", cyc_n, w.cyc);
                check("wr_we", int'(ram_we), int'(w.we));
                if (w.we) begin
                    check("wr_addr", int'(ram_addr), w.addr);
                    check("wr_data", int'(ram_wdata), w.data);
                end
            end
        end else if (ram_we) begin
            check("we_without_accept", 1, 0);
        end
        if (busy) run++;
        else if (run > 0) begin
            if (q_busy.size() == 0) check("busy_unexpected", run, 0);
            else check("busy_len", run, q_busy.pop_front());
            run = 0;
        end
        if (pix_tag_d) begin
            if (q_pix.size() == 0) check("pix_missing", 1, 0);
            else check("pix", int'(pix_data), q_pix.pop_front());
        end
        pix_tag_d = pix_tag;
        if (und_tag) begin
            if (q_und.size() == 0) check("und_missing", 1, 0);
            else check("underrun", int'(underrun), int'(q_und.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        for (int a = 0; a < NPIX; a++) begin
            mem[a]     = 12'(a);
            ref_mem[a] = 12'(a);
        end
        m_lb_row[0] = -1;
        m_lb_row[1] = -1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset(4);

        // Release at v=524; first write out of range, then random writes
        host_en  = 1'b1;
        wr_addr  = 17'(NPIX);
        wr_data  = 12'hABC;
        wr_valid = 1'b1;
        probe_und(0, 524);
        line(524, 1, 999);
        for (int v = 0; v < 4; v++) line(v, 0, 999);
        probe_und(650, 4);

        // Row 3 still loading when line 6 starts
        line(5, 600, 640);
        cyc(0, 6);
        line(6, 1, 639);
        probe_und(700, 6);
        line(6, 701, 760);
        do_reset(3);
        probe_und(700, 6);
        host_en = 1'b1;

        // Retrigger during a running fetch
        line(7, 630, 700);
        cyc(640, 7);
        line(7, 641, 999);
        probe_und(0, 8);
        line(8, 1, 999);

        // Reset at column 100 of a fetch, then a full refetch
        line(9, 630, 640);
        line(9, 641, 740);
        do_reset(2);
        probe_und(741, 9);
        host_en = 1'b1;
        line(9, 600, 999);
        line(10, 0, 999);
        line(11, 0, 999);

        host_en = 1'b0;
        for (int i = 0; i < 400 && wr_valid; i++) cyc(700, 12);
        check("wr_drain", int'(wr_valid), 0);
        repeat (3) cyc(700, 12);
        check("q_rd_left", q_rd.size(), 0);
        check("q_wr_left", q_wr.size(), 0);
        check("q_busy_left", q_busy.size(), 0);
        check("q_pix_left", q_pix.size(), 0);
        bad = 0;
        for (int a = 0; a < NPIX; a++) if (mem[a] !== ref_mem[a]) bad++;
        check("ram_image", bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
